// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the RAM port arbiter: FSM state encoding,
// bus width defaults and a grant-index width helper.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF    = 32;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned RAM_DEPTH_DEF = 32;
  localparam int unsigned STATE_W       = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // Width of a requester index; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin grant. Searches from last_i+1 (mod N_REQ);
// the pointer register itself lives in the parent.
module rr_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  int unsigned slot;
  logic        found;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    slot  = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      slot = (32'(last_i) + k) % N_REQ;
      if (!found && req_i[IDX_W'(slot)]) begin
        found                = 1'b1;
        gnt_c[IDX_W'(slot)]  = 1'b1;
        idx_c                = IDX_W'(slot);
      end
    end
    any_c = found;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between N_REQ valid/ready requesters, one
// transaction in flight, with address range checking and registered read data.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned RAM_DEPTH = RAM_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_wr,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    resp_err,
  output logic [DATA_W-1:0]       ram_data,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic                    ram_wr,
  input  logic [DATA_W-1:0]       ram_q,
  input  logic                    ram_state
);

  localparam int unsigned IDX_W = idx_width(N_REQ);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic                ram_wr_q, ram_wr_d;
  logic [N_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

  logic [N_REQ-1:0]    req_ready_c;
  logic [N_REQ-1:0]    gnt_c;
  logic [IDX_W-1:0]    gnt_idx_c;
  logic                gnt_any_c;
  logic                sel_wr_c;
  logic [ADDR_W-1:0]   sel_addr_c;
  logic [DATA_W-1:0]   sel_wdata_c;
  logic                in_range_c;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_c  (gnt_c),
    .idx_c  (gnt_idx_c),
    .any_c  (gnt_any_c)
  );

  // Payload of the requester that would win this cycle.
  assign sel_wr_c    = req_wr[gnt_idx_c];
  assign sel_addr_c  = req_addr[32'(gnt_idx_c)*ADDR_W +: ADDR_W];
  assign sel_wdata_c = req_wdata[32'(gnt_idx_c)*DATA_W +: DATA_W];
  assign in_range_c  = sel_addr_c < ADDR_W'(RAM_DEPTH);

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_wr_d     = 1'b0;
    resp_valid_d = '0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    req_ready_c  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any_c) begin
          req_ready_c = gnt_c;
          last_d      = gnt_idx_c;
          owner_d     = gnt_idx_c;
          wr_d        = sel_wr_c;
          if (in_range_c) begin
            // RAM bus only moves for legal addresses; errors leave it untouched.
            ram_addr_d = sel_addr_c;
            ram_data_d = sel_wdata_c;
            ram_wr_d   = sel_wr_c;
            resp_err_d = 1'b0;
            state_d    = ST_ACCESS;
          end else begin
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            resp_valid_d = gnt_c;
            state_d      = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (ram_state) begin
          resp_rdata_d = wr_q ? '0 : ram_q;
          resp_valid_d = N_REQ'(1) << owner_q;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pointer resets to the last slot so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_q       <= IDX_W'(N_REQ - 1);
      owner_q      <= '0;
      wr_q         <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_wr_q     <= 1'b0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_wr_q     <= ram_wr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = req_ready_c;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign ram_wr     = ram_wr_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_ram_port_arbiter;

  localparam int unsigned N_REQ = 2;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 32;

  localparam int MODE_RAND = 0;
  localparam int MODE_HOLD = 1;
  localparam int MODE_ONCE = 2;

  logic                  clk;
  logic                  rst_n;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ-1:0]      req_wr;
  logic [N_REQ*AW-1:0]   req_addr;
  logic [N_REQ*DW-1:0]   req_wdata;
  logic [N_REQ-1:0]      resp_valid;
  logic [DW-1:0]         resp_rdata;
  logic                  resp_err;
  logic [DW-1:0]         ram_data;
  logic [AW-1:0]         ram_addr;
  logic                  ram_wr;
  logic [DW-1:0]         ram_q;
  logic                  ram_state;

  int n_cmp;
  int n_fail;

  logic [DW-1:0] ram_mem   [DEPTH];
  logic [DW-1:0] model_mem [DEPTH];
  logic          ram_clr;

  int gseq[$];
  int hs_cyc[$];

  typedef struct {
    int          r;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[11];

  ram_port_arbiter #(
    .N_REQ     (N_REQ),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .RAM_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_data   (ram_data),
    .ram_addr   (ram_addr),
    .ram_wr     (ram_wr),
    .ram_q      (ram_q),
    .ram_state  (ram_state)
  );

  always #5 clk = ~clk;

  // Simple synchronous RAM: write and registered read at the same edge.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) ram_mem[i] <= '0;
    end else if (ram_wr) begin
      ram_mem[ram_addr[4:0]] <= ram_data;
    end
    ram_q <= ram_mem[ram_addr[4:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int r, input logic v, input logic wr,
                           input logic [31:0] addr, input logic [31:0] data);
    req_valid[r]          = v;
    req_wr[r]             = wr;
    req_addr[r*AW +: AW]  = addr;
    req_wdata[r*DW +: DW] = data;
  endtask

  task automatic reset_dut();
    req_valid = '0;
    ram_state = 1'b1;
    rst_n     = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // One isolated transaction; stall holds ram_state low for that many CAPTURE cycles.
  task automatic issue(input int r, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int exp_lat, input int stall,
                       input string name);
    int          waitc;
    int          lat;
    int          wrc;
    logic [31:0] addr0;
    logic        got;
    drive_req(r, 1'b1, wr, addr, wdata);
    #1;
    waitc = 0;
    while (!req_ready[r] && waitc < 20) begin
      step();
      waitc++;
    end
    check({name, " ready"}, 32'(req_ready), 32'(1 << r));
    if (!req_ready[r]) begin
      req_valid[r] = 1'b0;
      return;
    end
    addr0 = ram_addr;
    step();
    req_valid[r] = 1'b0;
    lat = 1;
    wrc = 0;
    got = 1'b0;
    while (lat <= 20) begin
      ram_state = !(stall > 0 && lat >= 2 && lat < 2 + stall);
      if (ram_wr) wrc++;
      if (req_ready != '0) check({name, " ready while busy"}, 32'(req_ready), 32'(0));
      if (resp_valid != '0) begin
        got = 1'b1;
        break;
      end
      step();
      lat++;
    end
    ram_state = 1'b1;
    check({name, " got resp"}, 32'(got), 32'(1));
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " resp_valid"}, 32'(resp_valid), 32'(1 << r));
    check({name, " rdata"}, resp_rdata, exp_rdata);
    check({name, " err"}, 32'(resp_err), 32'(exp_err));
    check({name, " ram_wr cycles"}, 32'(wrc), 32'((wr && !exp_err) ? 1 : 0));
    if (exp_err) check({name, " ram_addr held"}, ram_addr, addr0);
    if (wr && !exp_err) model_mem[addr[4:0]] = wdata;
    step();
  endtask

  // Cycle-level reference: grant by rotation from the last winner, fixed
  // service time per transaction, responses predicted from a memory array.
  task automatic run_model(input int ncyc, input int mode, input int max_new);
    logic             pend   [N_REQ];
    logic             p_wr   [N_REQ];
    logic [31:0]      p_addr [N_REQ];
    logic [31:0]      p_data [N_REQ];
    int               last;
    int               free;
    int               created;
    int               g;
    logic [N_REQ-1:0] exp_ready;
    logic [N_REQ-1:0] exp_resp;
    int               due_q[$];
    int               own_q[$];
    logic [31:0]      rd_q[$];
    logic             err_q[$];
    gseq.delete();
    hs_cyc.delete();
    last    = N_REQ - 1;
    free    = 0;
    created = 0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      pend[i]   = 1'b0;
      p_wr[i]   = 1'b0;
      p_addr[i] = '0;
      p_data[i] = '0;
    end
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (!pend[i]) begin
          logic mk;
          if (mode == MODE_RAND)      mk = (c < ncyc - 12) && ($urandom_range(0, 2) == 0);
          else if (mode == MODE_HOLD) mk = created < max_new;
          else                        mk = (c == 0);
          if (mk) begin
            pend[i] = 1'b1;
            created++;
            if (mode == MODE_RAND) begin
              p_wr[i]   = 1'($urandom_range(0, 1));
              p_addr[i] = ($urandom_range(0, 6) == 0) ? 32'(DEPTH + $urandom_range(0, 100))
                                                      : 32'($urandom_range(0, DEPTH - 1));
              p_data[i] = $urandom;
            end else begin
              p_wr[i]   = 1'b0;
              p_addr[i] = (i == 0) ? 32'd5 : 32'd31;
              p_data[i] = '0;
            end
          end
        end
      end
      for (int i = 0; i < int'(N_REQ); i++) drive_req(i, pend[i], p_wr[i], p_addr[i], p_data[i]);
      #1;
      exp_ready = '0;
      g = -1;
      if (c >= free) begin
        for (int k = 1; k <= int'(N_REQ); k++) begin
          int j;
          j = (last + k) % int'(N_REQ);
          if (g < 0 && pend[j]) g = j;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      check($sformatf("ready c%0d", c), 32'(req_ready), 32'(exp_ready));
      exp_resp = '0;
      if (due_q.size() > 0 && due_q[0] == c) begin
        exp_resp[own_q[0]] = 1'b1;
        check($sformatf("rdata c%0d", c), resp_rdata, rd_q[0]);
        check($sformatf("err c%0d", c), 32'(resp_err), 32'(err_q[0]));
        void'(due_q.pop_front());
        void'(own_q.pop_front());
        void'(rd_q.pop_front());
        void'(err_q.pop_front());
      end
      check($sformatf("resp_valid c%0d", c), 32'(resp_valid), 32'(exp_resp));
      if (g >= 0) begin
        logic bad;
        bad = p_addr[g] >= DEPTH;
        due_q.push_back(c + (bad ? 1 : 3));
        own_q.push_back(g);
        rd_q.push_back((bad || p_wr[g]) ? 32'h0 : model_mem[p_addr[g][4:0]]);
        err_q.push_back(bad);
        if (!bad && p_wr[g]) model_mem[p_addr[g][4:0]] = p_data[g];
        last = g;
        free = c + (bad ? 2 : 4);
        gseq.push_back(g);
        hs_cyc.push_back(c);
        pend[g] = 1'b0;
      end
      step();
    end
    check("responses drained", 32'(due_q.size()), 32'(0));
    req_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    ram_state = 1'b1;
    ram_clr   = 1'b1;
    n_cmp     = 0;
    n_fail    = 0;
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;

    tbl[0]  = '{0, 1'b1, 32'd5,          32'hDEADBEEF, 32'h0,        1'b0, 3};
    tbl[1]  = '{0, 1'b0, 32'd5,          32'h0,        32'hDEADBEEF, 1'b0, 3};
    tbl[2]  = '{1, 1'b1, 32'd31,         32'h12345678, 32'h0,        1'b0, 3};
    tbl[3]  = '{1, 1'b0, 32'd31,         32'h0,        32'h12345678, 1'b0, 3};
    tbl[4]  = '{1, 1'b0, 32'd32,         32'h0,        32'h0,        1'b1, 1};
    tbl[5]  = '{0, 1'b1, 32'd32,         32'h55555555, 32'h0,        1'b1, 1};
    tbl[6]  = '{0, 1'b0, 32'd0,          32'h0,        32'h0,        1'b0, 3};
    tbl[7]  = '{1, 1'b1, 32'd0,          32'hA5A5A5A5, 32'h0,        1'b0, 3};
    tbl[8]  = '{0, 1'b0, 32'd0,          32'h0,        32'hA5A5A5A5, 1'b0, 3};
    tbl[9]  = '{1, 1'b0, 32'hFFFFFFFF,   32'h0,        32'h0,        1'b1, 1};
    tbl[10] = '{0, 1'b0, 32'd31,         32'h0,        32'h12345678, 1'b0, 3};

    #1;
    check("reset req_ready", 32'(req_ready), 32'(0));
    check("reset resp_valid", 32'(resp_valid), 32'(0));
    check("reset resp_err", 32'(resp_err), 32'(0));
    check("reset resp_rdata", resp_rdata, 32'h0);
    check("reset ram_wr", 32'(ram_wr), 32'(0));
    check("reset ram_addr", ram_addr, 32'h0);
    check("reset ram_data", ram_data, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    ram_clr = 1'b0;
    rst_n   = 1'b1;

    // Both requesters raise valid together straight out of reset.
    run_model(14, MODE_ONCE, 2);
    check("once grant count", 32'(gseq.size()), 32'(2));
    if (gseq.size() == 2) begin
      check("once first grant", 32'(gseq[0]), 32'(0));
      check("once second grant", 32'(gseq[1]), 32'(1));
      check("once spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'(4));
    end

    for (int i = 0; i < 11; i++) begin
      issue(tbl[i].r, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata,
            tbl[i].exp_err, tbl[i].exp_lat, 0, $sformatf("vec%0d", i));
    end

    issue(1, 1'b0, 32'd31, 32'h0, 32'h12345678, 1'b0, 6, 3, "stall");

    reset_dut();
    run_model(30, MODE_HOLD, 6);
    check("hold grant count", 32'(gseq.size()), 32'(6));
    for (int k = 0; k < gseq.size() && k < 6; k++) begin
      check($sformatf("hold grant %0d", k), 32'(gseq[k]), 32'(k % 2));
    end

    reset_dut();
    run_model(400, MODE_RAND, 0);

    // Reset pulse while a write from requester 0 is in ACCESS.
    reset_dut();
    drive_req(0, 1'b1, 1'b1, 32'd20, 32'hCAFEF00D);
    #1;
    check("rstacc ready", 32'(req_ready), 32'(1));
    step();
    req_valid = '0;
    check("rstacc ram_wr before", 32'(ram_wr), 32'(1));
    rst_n = 1'b0;
    #1;
    check("rstacc ram_wr", 32'(ram_wr), 32'(0));
    check("rstacc ram_addr", ram_addr, 32'h0);
    check("rstacc ram_data", ram_data, 32'h0);
    check("rstacc resp_valid", 32'(resp_valid), 32'(0));
    check("rstacc resp_err", 32'(resp_err), 32'(0));
    check("rstacc resp_rdata", resp_rdata, 32'h0);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rstacc no resp %0d", k), 32'(resp_valid), 32'(0));
    end
    drive_req(0, 1'b1, 1'b0, 32'd5, 32'h0);
    drive_req(1, 1'b1, 1'b0, 32'd31, 32'h0);
    #1;
    check("rstacc next grant", 32'(req_ready), 32'(1));
    req_valid = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
